// File: rtl/phase_ring_controller.sv
// phase_ring_controller: actuated traffic-signal ring controller.
// Serves one phase at a time through GREEN -> YELLOW -> ALLRED. Calls are
// latched per phase and phases without a call are skipped. Emergency
// preemption and a sticky fault mode override normal ring operation.
// All state timing advances only on cycles where the 1 Hz tick strobe is high.
// Lamp outputs are registered from the next-state decode, so they change on
// the same clock edge as the state.
module phase_ring_controller #(
    parameter int NUM_PHASES  = 4,
    parameter int MIN_GREEN   = 5,
    parameter int MAX_GREEN   = 15,
    parameter int GAP_TIME    = 3,
    parameter int YELLOW_TIME = 3,
    parameter int ALLRED_TIME = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          tick,
    input  logic [NUM_PHASES-1:0]         demand,
    input  logic                          preempt_req,
    input  logic [$clog2(NUM_PHASES)-1:0] preempt_phase,
    input  logic                          fault_in,
    output logic [NUM_PHASES-1:0]         green,
    output logic [NUM_PHASES-1:0]         yellow,
    output logic [NUM_PHASES-1:0]         red,
    output logic [$clog2(NUM_PHASES)-1:0] active_phase,
    output logic                          fault_latched
);

    localparam int PW    = $clog2(NUM_PHASES);
    localparam int T_MAX = (MAX_GREEN > YELLOW_TIME)
                         ? ((MAX_GREEN > ALLRED_TIME) ? MAX_GREEN : ALLRED_TIME)
                         : ((YELLOW_TIME > ALLRED_TIME) ? YELLOW_TIME : ALLRED_TIME);
    localparam int TW    = $clog2(T_MAX + 1);
    localparam int GW    = $clog2(GAP_TIME + 1);

    localparam logic [TW-1:0] T_SAT    = TW'(T_MAX);
    localparam logic [TW-1:0] MIN_LAST = TW'(MIN_GREEN - 1);
    localparam logic [TW-1:0] MAX_LAST = TW'(MAX_GREEN - 1);
    localparam logic [TW-1:0] YEL_LAST = TW'(YELLOW_TIME - 1);
    localparam logic [TW-1:0] AR_LAST  = TW'(ALLRED_TIME - 1);
    localparam logic [GW-1:0] GAP_SAT  = GW'(GAP_TIME);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_TIME - 1);

    typedef enum logic [1:0] {
        S_ALLRED = 2'd0,
        S_GREEN  = 2'd1,
        S_YELLOW = 2'd2,
        S_FAULT  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [PW-1:0]         r_active;
    logic [PW-1:0]         w_active_nxt;
    logic [PW-1:0]         r_next_phase;
    logic [PW-1:0]         w_green_target;
    logic [PW-1:0]         w_ring_next;
    logic [TW-1:0]         r_timer;
    logic [GW-1:0]         r_gap;
    logic [NUM_PHASES-1:0] r_call;
    logic [NUM_PHASES-1:0] r_green;
    logic [NUM_PHASES-1:0] r_yellow;
    logic [NUM_PHASES-1:0] r_red;
    logic                  r_fault;
    logic [NUM_PHASES-1:0] w_green_nxt;
    logic [NUM_PHASES-1:0] w_yellow_nxt;
    logic [NUM_PHASES-1:0] w_red_nxt;
    logic                  w_fault_nxt;
    logic [NUM_PHASES-1:0] w_active_mask;
    logic [NUM_PHASES-1:0] w_next_mask;
    logic [NUM_PHASES-1:0] w_enter_mask;
    logic                  w_preempt_other;
    logic                  w_preempt_hold;
    logic                  w_other_call;
    logic                  w_max_hit;
    logic                  w_gap_hit;
    logic                  w_enter_green;

    // First phase after 'from' (ring order, wrapping) holding a call; the
    // active phase itself is never chosen while another candidate exists.
    function automatic logic [PW-1:0] ring_next(input logic [NUM_PHASES-1:0] calls,
                                                input logic [PW-1:0]         from);
        logic [PW-1:0] pick;
        logic          found;
        int            idx;
        pick  = from;
        found = 1'b0;
        for (int k = 1; k < NUM_PHASES; k++) begin
            idx = (int'(from) + k) % NUM_PHASES;
            if (!found && calls[idx]) begin
                pick  = PW'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign w_active_mask   = NUM_PHASES'(1) << r_active;
    assign w_next_mask     = NUM_PHASES'(1) << w_active_nxt;
    assign w_other_call    = |(r_call & ~w_active_mask);
    assign w_ring_next     = ring_next(r_call, r_active);
    assign w_preempt_other = preempt_req && (preempt_phase != r_active);
    assign w_preempt_hold  = preempt_req && (preempt_phase == r_active);
    assign w_max_hit       = (r_timer >= MAX_LAST);
    assign w_gap_hit       = (r_timer >= MIN_LAST) && !demand[r_active] && (r_gap >= GAP_LAST);
    assign w_green_target  = preempt_req ? preempt_phase : r_next_phase;
    assign w_enter_green   = (r_state == S_ALLRED) && (w_state_nxt == S_GREEN);
    assign w_enter_mask    = w_enter_green ? (NUM_PHASES'(1) << w_green_target) : '0;
    assign w_active_nxt    = w_enter_green ? w_green_target : r_active;

    // State register: current FSM state and the phase owning right-of-way.
    // NOTE: every clocked block uses non-blocking assignments so all registers
    // update from the same pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_ALLRED;
            r_active <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_active <= w_active_nxt;
        end
    end

    // Next-state decode; fault overrides everything, then preemption, then
    // max-out, then gap-out.
    // NOTE: the default assignment at the top of each combinational block keeps
    // every path driven, so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_ALLRED: begin
                if (tick && (r_timer == AR_LAST)) w_state_nxt = S_GREEN;
            end
            S_GREEN: begin
                if (w_preempt_other) begin
                    w_state_nxt = S_YELLOW;
                end else if (tick && !w_preempt_hold && w_other_call && (w_max_hit || w_gap_hit)) begin
                    w_state_nxt = S_YELLOW;
                end
            end
            S_YELLOW: begin
                if (tick && (r_timer == YEL_LAST)) w_state_nxt = S_ALLRED;
            end
            default: w_state_nxt = S_FAULT;
        endcase
        if (fault_in) w_state_nxt = S_FAULT;
    end

    // Lamp decode for the state being entered; red blinks per tick in FAULT.
    always_comb begin
        w_green_nxt  = '0;
        w_yellow_nxt = '0;
        w_red_nxt    = '1;
        w_fault_nxt  = 1'b0;
        case (w_state_nxt)
            S_GREEN: begin
                w_green_nxt = w_next_mask;
                w_red_nxt   = ~w_next_mask;
            end
            S_YELLOW: begin
                w_yellow_nxt = w_next_mask;
                w_red_nxt    = ~w_next_mask;
            end
            S_FAULT: begin
                w_fault_nxt = 1'b1;
                if (r_state != S_FAULT) w_red_nxt = '1;
                else if (tick)          w_red_nxt = ~r_red;
                else                    w_red_nxt = r_red;
            end
            default: w_red_nxt = '1;
        endcase
    end

    // Registered lamp and fault outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_green  <= '0;
            r_yellow <= '0;
            r_red    <= '1;
            r_fault  <= 1'b0;
        end else begin
            r_green  <= w_green_nxt;
            r_yellow <= w_yellow_nxt;
            r_red    <= w_red_nxt;
            r_fault  <= w_fault_nxt;
        end
    end

    // State timer, gap timer, call latches and pending next phase.
    // NOTE: the call register is reset along with the timers so no stale call
    // survives a reset and steers the ring.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer      <= '0;
            r_gap        <= '0;
            r_call       <= '0;
            r_next_phase <= '0;
        end else begin
            // State timer clears on every state change and saturates otherwise.
            if (w_state_nxt != r_state)                 r_timer <= '0;
            else if (tick && (r_timer != T_SAT))        r_timer <= r_timer + TW'(1);

            // Consecutive ticks without live demand on the green phase.
            if (w_state_nxt != r_state) begin
                r_gap <= '0;
            end else if ((r_state == S_GREEN) && tick) begin
                if (demand[r_active])        r_gap <= '0;
                else if (r_gap != GAP_SAT)   r_gap <= r_gap + GW'(1);
            end

            // Calls latch from live demand and clear as their phase turns green.
            if (r_state != S_FAULT) r_call <= (r_call | demand) & ~w_enter_mask;

            // Pending phase is chosen at the start of clearance and redirected
            // by any preemption request during clearance.
            if ((r_state == S_GREEN) && (w_state_nxt == S_YELLOW)) begin
                r_next_phase <= w_preempt_other ? preempt_phase : w_ring_next;
            end else if (((r_state == S_YELLOW) || (r_state == S_ALLRED)) && preempt_req) begin
                r_next_phase <= preempt_phase;
            end
        end
    end

    assign green         = r_green;
    assign yellow        = r_yellow;
    assign red           = r_red;
    assign active_phase  = r_active;
    assign fault_latched = r_fault;

endmodule

// File: tb/tb_phase_ring_controller.sv
// Bench for phase_ring_controller (4 phases, default timing).
// A tick-counting reference model predicts every lamp each cycle; directed
// scenarios add hand-computed literal checks at key instants.
module tb_phase_ring_controller;

    localparam int NP    = 4;
    localparam int PW    = 2;
    localparam int MIN_G = 5;
    localparam int MAX_G = 15;
    localparam int GAP   = 3;
    localparam int YEL   = 3;
    localparam int AR    = 2;

    logic          clk           = 1'b0;
    logic          rst_n         = 1'b0;
    logic          tick          = 1'b0;
    logic [NP-1:0] demand        = '0;
    logic          preempt_req   = 1'b0;
    logic [PW-1:0] preempt_phase = '0;
    logic          fault_in      = 1'b0;
    logic [NP-1:0] green;
    logic [NP-1:0] yellow;
    logic [NP-1:0] red;
    logic [PW-1:0] active_phase;
    logic          fault_latched;

    int checks = 0;
    int errors = 0;
    bit saw_g13 = 1'b0;

    phase_ring_controller #(
        .NUM_PHASES (NP),
        .MIN_GREEN  (MIN_G),
        .MAX_GREEN  (MAX_G),
        .GAP_TIME   (GAP),
        .YELLOW_TIME(YEL),
        .ALLRED_TIME(AR)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tick         (tick),
        .demand       (demand),
        .preempt_req  (preempt_req),
        .preempt_phase(preempt_phase),
        .fault_in     (fault_in),
        .green        (green),
        .yellow       (yellow),
        .red          (red),
        .active_phase (active_phase),
        .fault_latched(fault_latched)
    );

    always #5 clk = ~clk;

    // One-cycle tick strobe every third clock.
    initial begin : tick_gen
        int cyc;
        cyc = 0;
        forever begin
            @(negedge clk);
            tick = (cyc % 3 == 0);
            cyc++;
        end
    end

    // ---------------- reference model ----------------
    typedef enum {M_CLEAR, M_GO, M_CAUTION, M_BROKEN} mode_e;
    mode_e         m_mode;
    int            m_phase;
    int            m_pending;
    int            m_elapsed;
    int            m_quiet;
    logic [NP-1:0] m_call;
    bit            m_red_on;

    function automatic int first_call_after(input logic [NP-1:0] calls, input int from);
        for (int k = 1; k < NP; k++) begin
            if (calls[(from + k) % NP]) return (from + k) % NP;
        end
        return from;
    endfunction

    task automatic enter_caution(input int nxt);
        m_mode    = M_CAUTION;
        m_elapsed = 0;
        m_pending = nxt;
    endtask

    task automatic model_step();
        logic [NP-1:0] old_call;
        logic [NP-1:0] others;
        int n;
        int q;
        if (m_mode == M_BROKEN) begin
            if (tick) m_red_on = !m_red_on;
            return;
        end
        if (fault_in) begin
            m_mode   = M_BROKEN;
            m_red_on = 1'b1;
            return;
        end
        old_call = m_call;
        others   = old_call;
        others[m_phase] = 1'b0;
        m_call   = m_call | demand;
        case (m_mode)
            M_GO: begin
                if (preempt_req && int'(preempt_phase) != m_phase) begin
                    enter_caution(int'(preempt_phase));
                end else if (tick) begin
                    n = m_elapsed + 1;
                    q = demand[m_phase] ? 0 : m_quiet + 1;
                    m_elapsed = n;
                    m_quiet   = q;
                    if (!preempt_req && (others != '0) &&
                        (n >= MAX_G || (n >= MIN_G && q >= GAP)))
                        enter_caution(first_call_after(old_call, m_phase));
                end
            end
            M_CAUTION: begin
                if (preempt_req) m_pending = int'(preempt_phase);
                if (tick) begin
                    m_elapsed++;
                    if (m_elapsed == YEL) begin
                        m_mode    = M_CLEAR;
                        m_elapsed = 0;
                    end
                end
            end
            M_CLEAR: begin
                if (preempt_req) m_pending = int'(preempt_phase);
                if (tick) begin
                    m_elapsed++;
                    if (m_elapsed == AR) begin
                        m_mode          = M_GO;
                        m_phase         = m_pending;
                        m_call[m_phase] = 1'b0;
                        m_elapsed       = 0;
                        m_quiet         = 0;
                    end
                end
            end
            default: ;
        endcase
    endtask

    initial begin : model_proc
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_mode    = M_CLEAR;
                m_phase   = 0;
                m_pending = 0;
                m_elapsed = 0;
                m_quiet   = 0;
                m_call    = '0;
                m_red_on  = 1'b1;
            end else begin
                model_step();
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    initial begin : compare_proc
        logic [NP-1:0] oh;
        logic [NP-1:0] eg;
        logic [NP-1:0] ey;
        logic [NP-1:0] er;
        logic [PW-1:0] ea;
        logic          ef;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                oh = NP'(1) << m_phase;
                eg = '0;
                ey = '0;
                er = '1;
                ef = 1'b0;
                ea = PW'(m_phase);
                case (m_mode)
                    M_GO:      begin eg = oh; er = ~oh; end
                    M_CAUTION: begin ey = oh; er = ~oh; end
                    M_BROKEN:  begin er = m_red_on ? '1 : '0; ef = 1'b1; end
                    default: ;
                endcase
                checks++;
                if ({green, yellow, red, active_phase, fault_latched} !== {eg, ey, er, ea, ef}) begin
                    errors++;
                    $display("FAIL model_cmp @%0t: got g=%b y=%b r=%b ap=%0d fl=%b, want g=%b y=%b r=%b ap=%0d fl=%b",
                             $time, green, yellow, red, active_phase, fault_latched, eg, ey, er, ea, ef);
                end
                if (green[1] || green[3]) saw_g13 = 1'b1;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Return 1 time unit after the n-th following tick edge.
    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            while (!tick) @(posedge clk);
        end
        #1;
    endtask

    task automatic reset_pulse(input logic [NP-1:0] dem);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_red",    32'(red),           32'hF);
        check("rst_green",  32'(green),         32'h0);
        check("rst_yellow", 32'(yellow),        32'h0);
        check("rst_fault",  32'(fault_latched), 32'h0);
        check("rst_active", 32'(active_phase),  32'h0);
        demand      = dem;
        preempt_req = 1'b0;
        fault_in    = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : stim
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b1;

        // Rest: no demand, phase 0 green after two all-red ticks and held.
        wait_ticks(1);
        check("ar_tick1_green", 32'(green), 32'h0);
        check("ar_tick1_red",   32'(red),   32'hF);
        wait_ticks(1);
        check("first_green", 32'(green), 32'h1);
        wait_ticks(100);
        check("rest_100_green",  32'(green),        32'h1);
        check("rest_100_active", 32'(active_phase), 32'h0);

        // Reset during GREEN, then skip: only phase 2 calls.
        reset_pulse(4'b0100);
        saw_g13 = 1'b0;
        wait_ticks(2);
        check("skip_g0", 32'(green), 32'h1);
        wait_ticks(4);
        check("skip_g0_tick5", 32'(green), 32'h1);
        wait_ticks(1);
        check("skip_y0", 32'(yellow), 32'h1);
        wait_ticks(2);
        check("skip_y0_end", 32'(yellow), 32'h1);
        wait_ticks(1);
        check("skip_ar_red", 32'(red), 32'hF);
        wait_ticks(1);
        check("skip_ar_green", 32'(green), 32'h0);
        wait_ticks(1);
        check("skip_g2",        32'(green),        32'h4);
        check("skip_g2_active", 32'(active_phase), 32'h2);
        wait_ticks(20);
        check("skip_g2_rest", 32'(green), 32'h4);
        check("skip_never_g1_g3", 32'(saw_g13), 32'h0);

        // Max-out: phases 0 and 1 both demanding.
        reset_pulse(4'b0011);
        wait_ticks(2);
        check("max_g0", 32'(green), 32'h1);
        wait_ticks(14);
        check("max_g0_tick14", 32'(green), 32'h1);
        wait_ticks(1);
        check("max_y0", 32'(yellow), 32'h1);
        wait_ticks(5);
        check("max_g1", 32'(green), 32'h2);
        wait_ticks(14);
        check("max_g1_tick14", 32'(green), 32'h2);
        wait_ticks(1);
        check("max_y1", 32'(yellow), 32'h2);

        // Preemption toward phase 3 at green tick 2 of phase 0.
        reset_pulse(4'b0000);
        wait_ticks(2);
        check("pre_g0", 32'(green), 32'h1);
        wait_ticks(2);
        preempt_req   = 1'b1;
        preempt_phase = 2'd3;
        @(posedge clk);
        #1;
        check("pre_y0_next_cycle", 32'(yellow), 32'h1);
        wait_ticks(2);
        check("pre_y0_hold", 32'(yellow), 32'h1);
        wait_ticks(1);
        check("pre_ar", 32'(red), 32'hF);
        wait_ticks(2);
        check("pre_g3", 32'(green), 32'h8);
        demand = 4'b1001;
        wait_ticks(20);
        check("pre_g3_hold", 32'(green), 32'h8);
        preempt_req = 1'b0;
        wait_ticks(1);
        check("post_release_maxout", 32'(yellow), 32'h8);
        wait_ticks(5);
        check("post_ring_g0", 32'(green), 32'h1);

        // Fault during preempted GREEN.
        reset_pulse(4'b0000);
        wait_ticks(2);
        preempt_req   = 1'b1;
        preempt_phase = 2'd0;
        fault_in      = 1'b1;
        @(posedge clk);
        #1;
        fault_in = 1'b0;
        check("fault_green_off", 32'(green),         32'h0);
        check("fault_red_on",    32'(red),           32'hF);
        check("fault_latched",   32'(fault_latched), 32'h1);
        wait_ticks(1);
        check("fault_blink_off", 32'(red), 32'h0);
        wait_ticks(1);
        check("fault_blink_on", 32'(red), 32'hF);
        demand = 4'b1111;
        wait_ticks(10);
        check("fault_sticky", 32'(fault_latched), 32'h1);
        check("fault_no_green", 32'(green), 32'h0);
        reset_pulse(4'b0000);
        wait_ticks(2);
        check("after_fault_g0", 32'(green), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
